// File: rtl/axi_burst_master_if.sv
// AXI-style read/write channel bundle between the burst master and the slave
// interconnect. Command payloads are packed {addr,len,id}.
interface axi_burst_master_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4,
    parameter int ID_W   = 4,
    parameter int DATA_W = 8
);
    localparam int CMD_W = ADDR_W + LEN_W + ID_W;

    // read address channel
    logic              ARVALID;
    logic              ARREADY;
    logic [CMD_W-1:0]  ARCMD;
    // read data channel
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    // write address channel
    logic              AWVALID;
    logic              AWREADY;
    logic [CMD_W-1:0]  AWCMD;
    // write data channel
    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WLAST;
    // write response channel
    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;

    modport master (
        output ARVALID, ARCMD, RREADY,
        output AWVALID, AWCMD, WVALID, WDATA, WLAST, BREADY,
        input  ARREADY, RVALID, RDATA, RRESP, RLAST,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  ARVALID, ARCMD, RREADY,
        input  AWVALID, AWCMD, WVALID, WDATA, WLAST, BREADY,
        output ARREADY, RVALID, RDATA, RRESP, RLAST,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_burst_master.sv
// Burst master with independent read and write engines. Each engine accepts a
// packed {addr,len,id} command, runs one handshaked burst of len+1 beats,
// buffers read data or streams snapshotted write data, and flags bad responses.
module axi_burst_master #(
    parameter int ADDR_W    = 8,
    parameter int LEN_W     = 4,
    parameter int ID_W      = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rd_start,
    input  logic [ADDR_W+LEN_W+ID_W-1:0]        rd_cmd,
    output logic                                rd_busy,
    output logic                                rd_done,
    output logic                                rd_err,
    output logic [MAX_BURST*DATA_W-1:0]         rd_buf,
    input  logic                                wr_start,
    input  logic [ADDR_W+LEN_W+ID_W-1:0]        wr_cmd,
    input  logic [MAX_BURST*DATA_W-1:0]         wr_data,
    output logic                                wr_busy,
    output logic                                wr_done,
    output logic                                wr_err,
    axi_burst_master_if.master                  bus
);
    localparam int CMD_W = ADDR_W + LEN_W + ID_W;
    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} rd_state_t;
    typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_RESP, W_DONE} wr_state_t;

    // ---------------------------------------------------------------- read
    rd_state_t                   rd_state_reg, rd_state_next;
    logic [CMD_W-1:0]            ar_cmd_reg;
    logic [CNT_W-1:0]            rd_cnt_reg;
    logic                        rd_err_reg;
    logic [MAX_BURST*DATA_W-1:0] rd_buf_reg;
    logic [LEN_W-1:0]            rd_len;
    logic                        rd_accept;
    logic                        r_beat;
    logic                        rd_last_slot;

    assign rd_len       = ar_cmd_reg[ID_W +: LEN_W];
    assign rd_accept    = (rd_state_reg == R_IDLE) && rd_start;
    assign r_beat       = (rd_state_reg == R_DATA) && bus.RVALID;
    assign rd_last_slot = (rd_cnt_reg == {1'b0, rd_len});

    assign bus.ARCMD = ar_cmd_reg;
    assign rd_err    = rd_err_reg;
    assign rd_buf    = rd_buf_reg;

    // Read FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_state_reg <= R_IDLE;
        else      rd_state_reg <= rd_state_next;
    end

    // Read FSM next-state and channel/status decode
    always_comb begin
        rd_state_next = rd_state_reg;
        bus.ARVALID   = 1'b0;
        bus.RREADY    = 1'b0;
        rd_busy       = 1'b0;
        rd_done       = 1'b0;
        case (rd_state_reg)
            R_IDLE: if (rd_start) rd_state_next = R_AR;
            R_AR: begin
                bus.ARVALID = 1'b1;
                rd_busy     = 1'b1;
                if (bus.ARREADY) rd_state_next = R_DATA;
            end
            R_DATA: begin
                bus.RREADY = 1'b1;
                rd_busy    = 1'b1;
                if (bus.RVALID && bus.RLAST) rd_state_next = R_DONE;
            end
            R_DONE: begin
                rd_done       = 1'b1;
                rd_state_next = R_IDLE;
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Read datapath: command latch, beat counter, sticky error, beat buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_cmd_reg <= '0;
            rd_cnt_reg <= '0;
            rd_err_reg <= 1'b0;
            rd_buf_reg <= '0;
        end else if (rd_accept) begin
            ar_cmd_reg <= rd_cmd;
            rd_cnt_reg <= '0;
            rd_err_reg <= 1'b0;
            rd_buf_reg <= '0;
        end else if (r_beat) begin
            // beats beyond the buffer match no slot and are dropped
            for (int i = 0; i < MAX_BURST; i++) begin
                if (rd_cnt_reg == CNT_W'(i)) rd_buf_reg[i*DATA_W +: DATA_W] <= bus.RDATA;
            end
            // saturate rather than wrap so a runaway slave cannot alias slot 0
            if (rd_cnt_reg != {CNT_W{1'b1}}) rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
            if ((bus.RRESP != 2'b00) || (bus.RLAST != rd_last_slot)) rd_err_reg <= 1'b1;
        end
    end

    // --------------------------------------------------------------- write
    wr_state_t                   wr_state_reg, wr_state_next;
    logic [CMD_W-1:0]            aw_cmd_reg;
    logic [MAX_BURST*DATA_W-1:0] wr_data_reg;
    logic [CNT_W-1:0]            wr_cnt_reg;
    logic                        wr_err_reg;
    logic [LEN_W-1:0]            wr_len;
    logic                        wr_accept;
    logic                        w_beat;
    logic                        b_hs;
    logic                        wr_last_slot;
    logic [DATA_W-1:0]           wr_beat_data;

    assign wr_len       = aw_cmd_reg[ID_W +: LEN_W];
    assign wr_accept    = (wr_state_reg == W_IDLE) && wr_start;
    assign w_beat       = (wr_state_reg == W_DATA) && bus.WREADY;
    assign b_hs         = (wr_state_reg == W_RESP) && bus.BVALID;
    assign wr_last_slot = (wr_cnt_reg == {1'b0, wr_len});

    assign bus.AWCMD = aw_cmd_reg;
    assign wr_err    = wr_err_reg;

    // Select the current write beat from the snapshotted payload
    always_comb begin
        wr_beat_data = '0;
        for (int i = 0; i < MAX_BURST; i++) begin
            if (wr_cnt_reg == CNT_W'(i)) wr_beat_data = wr_data_reg[i*DATA_W +: DATA_W];
        end
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wr_state_reg <= W_IDLE;
        else      wr_state_reg <= wr_state_next;
    end

    // Write FSM next-state and channel/status decode
    always_comb begin
        wr_state_next = wr_state_reg;
        bus.AWVALID   = 1'b0;
        bus.WVALID    = 1'b0;
        bus.WDATA     = '0;
        bus.WLAST     = 1'b0;
        bus.BREADY    = 1'b0;
        wr_busy       = 1'b0;
        wr_done       = 1'b0;
        case (wr_state_reg)
            W_IDLE: if (wr_start) wr_state_next = W_AW;
            W_AW: begin
                bus.AWVALID = 1'b1;
                wr_busy     = 1'b1;
                if (bus.AWREADY) wr_state_next = W_DATA;
            end
            W_DATA: begin
                bus.WVALID = 1'b1;
                bus.WDATA  = wr_beat_data;
                bus.WLAST  = wr_last_slot;
                wr_busy    = 1'b1;
                if (bus.WREADY && wr_last_slot) wr_state_next = W_RESP;
            end
            W_RESP: begin
                bus.BREADY = 1'b1;
                wr_busy    = 1'b1;
                if (bus.BVALID) wr_state_next = W_DONE;
            end
            W_DONE: begin
                wr_done       = 1'b1;
                wr_state_next = W_IDLE;
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    // Write datapath: command/payload snapshot, beat counter, response error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_cmd_reg  <= '0;
            wr_data_reg <= '0;
            wr_cnt_reg  <= '0;
            wr_err_reg  <= 1'b0;
        end else if (wr_accept) begin
            aw_cmd_reg  <= wr_cmd;
            wr_data_reg <= wr_data;
            wr_cnt_reg  <= '0;
            wr_err_reg  <= 1'b0;
        end else begin
            if (w_beat && !wr_last_slot) wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
            if (b_hs) wr_err_reg <= (bus.BRESP != 2'b00);
        end
    end
endmodule
